// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared types and defaults for the FFT stage controller
//   state_t      - controller state (IDLE, RUN)
//   FRAME_CNT_W  - width of the completed-frame counter
//   DEF_NUM/DATA - default samples per cycle / samples per frame
package fft_ctrl_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int FRAME_CNT_W = 16;
  localparam int DEF_NUM = 16;
  localparam int DEF_DATA = 512;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-stage shift register with async active-low clear
//   clk, rstn - clock, asynchronous active-low clear
//   d_i       - tag entering stage 0
//   q_o       - tag leaving the last stage (DEPTH cycles later)
//   any_o     - 1 when any stage holds a tag whose MSB (valid) is set
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         any_o
);
  logic [DEPTH-1:0][W-1:0] sr_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '0;
    else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  always_comb begin
    any_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_o = any_o | sr_q[i][W-1];
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: framing check and sequencing for one radix-2 butterfly stage
//   clk, rstn                   - clock, asynchronous active-low reset
//   valid_in, sof_in            - upstream block valid and start-of-frame
//   bfly_en, blk_idx, upper_half - butterfly enable, block index, upper-half flag
//   valid_out, sof_out, eof_out - latency-matched flags for the next stage
//   frame_err                   - one-cycle pulse on a framing violation
//   frame_cnt                   - completed frames (wrapping)
//   busy                        - frame in progress or blocks still in flight
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int NUM = DEF_NUM,
  parameter int DATA = DEF_DATA,
  parameter int LATENCY = 3,
  parameter int COUNT = DATA / NUM,
  parameter int CNT_W = $clog2(COUNT)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_in,
  input  logic                   sof_in,
  output logic                   bfly_en,
  output logic [CNT_W-1:0]       blk_idx,
  output logic                   upper_half,
  output logic                   valid_out,
  output logic                   sof_out,
  output logic                   eof_out,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(COUNT / 2);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_d;
  logic run, start, cont, accept, last, err, pipe_busy;
  logic [2:0] tag_out;
  // A sof always opens a new frame; in RUN it also abandons the old one.
  always_comb begin
    run = state_q == RUN;
    start = valid_in & sof_in;
    cont = run & valid_in & ~sof_in;
    accept = start | cont;
    idx_d = start ? '0 : CNT_W'(cnt_q + 1'b1);
    last = cont & idx_d == LAST;
    err = run ? ~valid_in | sof_in : valid_in & ~sof_in;
    state_d = accept & ~last ? RUN : IDLE;
    cnt_d = accept & ~last ? idx_d : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bfly_en <= 1'b0;
      blk_idx <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bfly_en <= accept;
      blk_idx <= accept ? idx_d : blk_idx;
      frame_err <= err;
      frame_cnt <= frame_cnt + FRAME_CNT_W'(last);
    end
  end
  valid_delay_line #(.DEPTH(LATENCY), .W(3)) u_dly (
    .clk  (clk),
    .rstn (rstn),
    .d_i  ({accept, start, last}),
    .q_o  (tag_out),
    .any_o(pipe_busy)
  );
  assign valid_out = tag_out[2];
  assign sof_out = tag_out[1];
  assign eof_out = tag_out[0];
  assign upper_half = blk_idx >= HALF;
  assign busy = run | pipe_busy;
endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencing controller for one radix-2 butterfly stage of the FFT pipeline. A frame of DATA complex samples arrives NUM samples per cycle. The controller:
- validates frame framing (start-of-frame marker, contiguous blocks);
- drives the stage's butterfly enable and block index;
- produces latency-matched valid, start-of-frame and end-of-frame flags for the next stage;
- reports framing errors.

It sits between the upstream stage output and the butterfly datapath plus its output register.

## Interface
Parameters:
- NUM, 16: samples per cycle (lines).
- DATA, 512: samples per frame.
- LATENCY, 3: cycles from valid_in to datapath output; must be ≥ 1.
- COUNT, DATA/NUM: blocks per frame (derived); must be ≥ 2.
- CNT_W, $clog2(COUNT): block index width (derived).

Ports:
- clk, in, 1: single clock, rising edge.
- rstn, in, 1: asynchronous active-low reset.
- valid_in, in, 1: input block valid.
- sof_in, in, 1: first block of frame; qualified by valid_in.
- bfly_en, out, 1: butterfly compute enable for the block now at the datapath.
- blk_idx, out, CNT_W: index (0..COUNT-1) of that block.
- upper_half, out, 1: 1 when blk_idx ≥ COUNT/2; used for twiddle/pair selection.
- valid_out, out, 1: datapath output valid.
- sof_out, out, 1: first output block of a complete-so-far frame.
- eof_out, out, 1: last output block of a frame.
- frame_err, out, 1: one-cycle pulse on a framing violation.
- frame_cnt, out, 16: completed frames, wraps at 2^16.
- busy, out, 1: state is RUN or pipeline holds a valid block.

## Operation
- States: IDLE, RUN. Reset enters IDLE with count = 0.
- Acceptance rules:
  - IDLE: valid_in & sof_in is accepted as block 0 and goes to RUN.
  - IDLE: valid_in & !sof_in is dropped (no bfly_en) and pulses frame_err.
  - RUN: valid_in & !sof_in is accepted as block count+1.
  - RUN: when the accepted block is COUNT-1, return to IDLE, increment frame_cnt and tag the block eof.
- Abort: in RUN with valid_in=0:
  - pulse frame_err, go to IDLE, clear count;
  - blocks already in flight still emerge with valid_out;
  - eof_out is never asserted for the aborted frame;
  - frame_cnt is unchanged.
- Restart: in RUN, valid_in & sof_in means the previous frame is abandoned:
  - pulse frame_err;
  - accept the block as block 0 of a new frame and stay in RUN.
- Back-to-back frames: block COUNT-1 followed directly by sof in the next cycle needs no bubble.
- Simultaneous events: sof_in on the cycle block COUNT-1 is expected counts as a restart. It raises an error and the old frame gets no eof.
- upper_half is a combinational decode of registered blk_idx.

## Timing
- Reset value of every output is 0. Reset mid-frame clears state, count and the delay line immediately, with no drain.
- bfly_en, blk_idx: registered, 1 cycle after the accepting valid_in edge. When bfly_en=0, blk_idx holds its last value.
- valid_out, sof_out, eof_out: exactly LATENCY cycles after the accepting valid_in edge.
  - These are implemented as a LATENCY-deep shift of {accepted, sof_tag, eof_tag}.
  - sof_out is the sof tag; eof_out is the eof tag.
- frame_err: registered, 1 cycle after the offending edge.
- frame_cnt: increments 1 cycle after block COUNT-1 is accepted.
- Throughput: one block per cycle, no backpressure; the downstream stage must always accept.

## Structure
- Package fft_ctrl_pkg:
  - state enum (IDLE, RUN);
  - frame_cnt width constant (16);
  - shared default NUM/DATA constants.
- Sub-module valid_delay_line: parameterized depth and width shift register with async active-low clear. It carries the 3-bit tag {valid, sof, eof}.
- Top: FSM, block counter, error/frame counter logic.

## Test plan
- Clean frame, DATA=512, NUM=16: sof + 32 contiguous valid blocks.
  - bfly_en cycles 1–32 with blk_idx 0..31;
  - upper_half for idx 16..31;
  - valid_out cycles 3–34, sof_out at cycle 3, eof_out at cycle 34;
  - frame_cnt=1, frame_err never.
- Two back-to-back frames (64 valid cycles, sof at cycles 0 and 32) -> blk_idx wraps 31→0 with no gap; eof_out at cycles 34 and 66; frame_cnt=2.
- Gap after block 9:
  - frame_err pulse one cycle after the gap;
  - 10 valid_out blocks, no eof_out;
  - frame_cnt unchanged;
  - next sof accepted as blk_idx 0.
- valid_in without sof in IDLE for 5 cycles -> no bfly_en, no valid_out, frame_err at each of the 5 cycles.
- sof reasserted at block 20 -> frame_err, blk_idx restarts at 0, and the full frame that follows completes with eof and frame_cnt+1.
- rstn deasserted at block 15 -> all outputs 0 asynchronously; after release, a clean frame behaves identically to scenario 1.
